// File: rtl/axis_filler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_filler_pkg
// Purpose  : Shared types and constants for the AXI-Stream filler generator.
// Revision : 1.0 - initial release
// ============================================================================
package axis_filler_pkg;

    // Top-level FSM states: between packets, passing upstream, filler, gap.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_FILL = 2'd2,
        S_GAP  = 2'd3
    } filler_state_e;

    // Width of the optional completed-filler-packet counter.
    localparam int FILL_CNT_W = 16;

endpackage : axis_filler_pkg
`default_nettype wire

// File: rtl/axi_stream_inf.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_inf
// Purpose  : Minimal AXI-Stream interface carrying clock and reset with the
//            stream signals; master/slaver modports.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_stream_inf #(
    parameter int DSIZE = 8
) (
    input logic aclk,
    input logic aresetn
);
    localparam int KSIZE = (DSIZE + 7) / 8;

    logic             tvalid;
    logic             tready;
    logic [DSIZE-1:0] tdata;
    logic [KSIZE-1:0] tkeep;
    logic             tuser;
    logic             tlast;

    modport master (
        input  aclk, aresetn, tready,
        output tvalid, tdata, tkeep, tuser, tlast
    );

    modport slaver (
        input  aclk, aresetn, tvalid, tdata, tkeep, tuser, tlast,
        output tready
    );
endinterface : axi_stream_inf
`default_nettype wire

// File: rtl/axis_filler.sv
`default_nettype none
// ============================================================================
// Module   : axis_filler
// Purpose  : Packet-aligned filler generator. With button high the upstream
//            stream passes through combinationally; with button low upstream
//            is held off and fixed filler packets (FILL_LEN beats followed by
//            FILL_GAP idle cycles) are sent. Switching only at packet edges.
// Options  : AXIS_FILLER_CNT_EN adds the fill_pkt_cnt port (16-bit wrapping
//            count of completed filler packets).
// Revision : 1.0 - initial release
// ============================================================================
module axis_filler
    import axis_filler_pkg::*;
#(
    parameter int               DSIZE     = 8,   // must match the interfaces
    parameter int               FILL_LEN  = 4,
    parameter int               FILL_GAP  = 2,
    parameter logic [DSIZE-1:0] FILL_DATA = '0
) (
    input  logic                  button,
    axi_stream_inf.slaver         axis_in,
    axi_stream_inf.master         axis_out
`ifdef AXIS_FILLER_CNT_EN
    ,
    output logic [FILL_CNT_W-1:0] fill_pkt_cnt
`endif
);

    localparam int BEAT_W = $clog2(FILL_LEN + 1);
    // A zero-length gap still needs a 1-bit counter to keep widths legal.
    localparam int GAP_W  = (FILL_GAP > 0) ? $clog2(FILL_GAP + 1) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FILL_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(FILL_GAP - 1);

    logic              clk;
    logic              rstn;
    filler_state_e     state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              pass_sel;
    logic              fill_sel;
    logic              fill_last;
    logic              out_hs;

    assign clk  = axis_in.aclk;
    assign rstn = axis_in.aresetn;

    // Which source owns axis_out this cycle; button only matters in S_IDLE.
    assign pass_sel  = (state == S_PASS) || ((state == S_IDLE) && button);
    assign fill_sel  = (state == S_FILL) || ((state == S_IDLE) && !button);
    assign fill_last = (state == S_IDLE) ? (FILL_LEN == 1) : (beat_cnt == BEAT_LAST);
    assign out_hs    = axis_out.tvalid && axis_out.tready;

    // Output mux: combinational pass path, constant filler beats, quiet gap.
    always_comb begin
        axis_out.tvalid = 1'b0;
        axis_out.tdata  = '0;
        axis_out.tkeep  = '0;
        axis_out.tuser  = 1'b0;
        axis_out.tlast  = 1'b0;
        axis_in.tready  = 1'b0;
        if (rstn) begin
            if (pass_sel) begin
                axis_out.tvalid = axis_in.tvalid;
                axis_out.tdata  = axis_in.tdata;
                axis_out.tkeep  = axis_in.tkeep;
                axis_out.tuser  = axis_in.tuser;
                axis_out.tlast  = axis_in.tlast;
                axis_in.tready  = axis_out.tready;
            end else if (fill_sel) begin
                axis_out.tvalid = 1'b1;
                axis_out.tdata  = FILL_DATA;
                axis_out.tkeep  = '1;
                axis_out.tlast  = fill_last;
            end
        end
    end

    // Packet-boundary FSM with beat and gap counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (button) begin
                        if (out_hs && !axis_in.tlast) begin
                            state <= S_PASS;
                        end
                    end else if (out_hs) begin
                        if (FILL_LEN == 1) begin
                            gap_cnt <= '0;
                            if (FILL_GAP != 0) begin
                                state <= S_GAP;
                            end
                        end else begin
                            state    <= S_FILL;
                            beat_cnt <= BEAT_W'(1);
                        end
                    end
                end
                S_PASS: begin
                    if (out_hs && axis_in.tlast) begin
                        state <= S_IDLE;
                    end
                end
                S_FILL: begin
                    if (out_hs) begin
                        if (fill_last) begin
                            beat_cnt <= '0;
                            gap_cnt  <= '0;
                            state    <= (FILL_GAP != 0) ? S_GAP : S_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AXIS_FILLER_CNT_EN
    // Count filler packets on their tlast handshake; wraps naturally.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fill_pkt_cnt <= '0;
        end else if (fill_sel && out_hs && fill_last) begin
            fill_pkt_cnt <= fill_pkt_cnt + FILL_CNT_W'(1);
        end
    end
`endif

endmodule : axis_filler
`default_nettype wire
